// File: rtl/sevenseg_scan_ctrl.sv
// Time-multiplexed scan controller for a common-anode seven-segment display.
// One shared decoder; frame-aligned double buffering of the digit contents.
module sevenseg_scan_ctrl #(
  parameter int NUM_DIGITS = 4,
  parameter int DWELL      = 1000,
  parameter int GUARD      = 2
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          load,
  input  logic [4*NUM_DIGITS-1:0]       load_data,
  input  logic [NUM_DIGITS-1:0]         load_blank,
  output logic [3:0]                    dec_data,
  input  logic [6:0]                    dec_segments,
  output logic [6:0]                    seg_out,
  output logic [NUM_DIGITS-1:0]         digit_en,
  output logic [$clog2(NUM_DIGITS)-1:0] digit_idx,
  output logic                          frame_done
);

  localparam int IW      = $clog2(NUM_DIGITS);
  localparam int CNT_MAX = (DWELL > GUARD) ? DWELL : GUARD;
  localparam int CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

  localparam logic [CW-1:0] GUARD_LAST = CW'(GUARD - 1);
  localparam logic [CW-1:0] DWELL_LAST = CW'(DWELL - 1);
  localparam logic [IW-1:0] IDX_LAST   = IW'(NUM_DIGITS - 1);

  typedef enum logic {
    BLANK = 1'b0,
    DRIVE = 1'b1
  } state_t;

  state_t                  state, state_d;
  logic [CW-1:0]           cnt, cnt_d;
  logic [IW-1:0]           idx_d;
  logic [NUM_DIGITS-1:0]   en_d;
  logic [NUM_DIGITS-1:0]   onehot;
  logic [6:0]              seg_d;
  logic                    frame_done_d;

  logic [4*NUM_DIGITS-1:0] act_data, shadow_data;
  logic [NUM_DIGITS-1:0]   act_blank, shadow_blank;
  logic                    pending;
  logic                    wrap;

  assign dec_data = act_data[digit_idx*4 +: 4];
  assign onehot   = {{(NUM_DIGITS-1){1'b0}}, 1'b1} << digit_idx;
  assign wrap     = (state == DRIVE) && (cnt == DWELL_LAST) && (digit_idx == IDX_LAST);

  always_comb begin
    state_d      = state;
    cnt_d        = cnt + 1'b1;
    idx_d        = digit_idx;
    en_d         = digit_en;
    seg_d        = seg_out;
    frame_done_d = 1'b0;
    case (state)
      BLANK: begin
        en_d  = '0;
        seg_d = '0;
        if (cnt == GUARD_LAST) begin
          state_d = DRIVE;
          cnt_d   = '0;
          en_d    = act_blank[digit_idx] ? '0 : onehot;
          seg_d   = dec_segments;
        end
      end
      DRIVE: begin
        seg_d = dec_segments;
        if (cnt == DWELL_LAST) begin
          state_d      = BLANK;
          cnt_d        = '0;
          en_d         = '0;
          seg_d        = '0;
          idx_d        = (digit_idx == IDX_LAST) ? '0 : digit_idx + 1'b1;
          frame_done_d = (digit_idx == IDX_LAST);
        end
      end
      default: state_d = BLANK;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= BLANK;
      cnt        <= '0;
      digit_idx  <= '0;
      digit_en   <= '0;
      seg_out    <= '0;
      frame_done <= 1'b0;
    end else begin
      state      <= state_d;
      cnt        <= cnt_d;
      digit_idx  <= idx_d;
      digit_en   <= en_d;
      seg_out    <= seg_d;
      frame_done <= frame_done_d;
    end
  end

  // load is a bare one-cycle strobe with no backpressure: it is always accepted.
  // Data lands in the shadow buffer and is promoted only on the wrap edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      act_data     <= '0;
      act_blank    <= '0;
      shadow_data  <= '0;
      shadow_blank <= '0;
      pending      <= 1'b0;
    end else begin
      if (load) begin
        shadow_data  <= load_data;
        shadow_blank <= load_blank;
      end
      if (wrap) begin
        pending <= 1'b0;
        if (load) begin
          act_data  <= load_data;
          act_blank <= load_blank;
        end else if (pending) begin
          act_data  <= shadow_data;
          act_blank <= shadow_blank;
        end
      end else if (load) begin
        pending <= 1'b1;
      end
    end
  end

endmodule
